// File: rtl/gpio_irq_status.sv
// GPIO interrupt status/latch: synchronised pins, per-bit trigger modes,
// W1C / optional read-clear, sticky overflow, mask and a single irq line.

module gpio_irq_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic       warm,
  input  logic [2:0] trig,
  input  logic       wclr,
  input  logic       rclr_en,
  input  logic       clr,
  output logic       status,
  output logic       ovf,
  output logic       status_nxt
);
  logic [SYNC_STAGES-1:0] sync;
  logic s, prev, rise, fall, ev, ev_raw, ovf_nxt, rclr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_comb begin
    ev_raw = 1'b0;
    case (trig)
      3'b001:  ev_raw = s;
      3'b010:  ev_raw = ~s;
      3'b011:  ev_raw = rise;
      3'b100:  ev_raw = fall;
      3'b101:  ev_raw = rise | fall;
      default: ev_raw = 1'b0;
    endcase
  end

  // Nothing fires until the sync chain and prev hold real pin samples.
  assign ev   = ev_raw & warm;
  assign rclr = rclr_en & status;

  always_comb begin
    status_nxt = 1'b0;
    ovf_nxt    = 1'b0;
    if (!clr) begin
      status_nxt = ev | (status & ~wclr & ~rclr);
      ovf_nxt    = (ev & status) | (ovf & ~wclr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= RST_BIT;
      ovf    <= 1'b0;
    end else begin
      status <= status_nxt;
      ovf    <= ovf_nxt;
    end
  end
endmodule

module gpio_irq_status #(
  parameter int             DW          = 8,
  parameter int             SYNC_STAGES = 2,
  parameter bit             RC_MODE     = 1'b0,
  parameter logic [DW-1:0]  RST_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ren_i,
  input  logic            wen_i,
  input  logic [DW-1:0]   di_i,
  input  logic [DW-1:0]   pin_i,
  input  logic [3*DW-1:0] trig_i,
  input  logic [DW-1:0]   mask_i,
  input  logic            clr_i,
  output logic [DW-1:0]   reg_o,
  output logic [DW-1:0]   ovf_o,
  output logic [DW-1:0]   pend_o,
  output logic            irq_o
);
  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CNT_W    = $clog2(WARM_MAX + 1);

  logic [CNT_W-1:0]    warm_cnt;
  logic                warm;
  logic [DW-1:0][2:0]  trig_m;
  logic [DW-1:0]       wclr, status_nxt;
  logic                rclr_en;

  // Saturating warm-up counter, restarts from 0 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       warm_cnt <= '0;
    else if (!warm) warm_cnt <= warm_cnt + 1'b1;
  end

  assign warm    = (warm_cnt == CNT_W'(WARM_MAX));
  assign trig_m  = trig_i;
  assign wclr    = wen_i ? di_i : '0;
  assign rclr_en = RC_MODE & ren_i;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    gpio_irq_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_BIT     (RST_VAL[i])
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .pin        (pin_i[i]),
      .warm       (warm),
      .trig       (trig_m[i]),
      .wclr       (wclr[i]),
      .rclr_en    (rclr_en),
      .clr        (clr_i),
      .status     (reg_o[i]),
      .ovf        (ovf_o[i]),
      .status_nxt (status_nxt[i])
    );
  end

  assign pend_o = reg_o & mask_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_o <= 1'b0;
    else      irq_o <= |(status_nxt & mask_i);
  end
endmodule

// File: tb/tb_gpio_irq_status.sv
// Directed + randomized bench for gpio_irq_status against a pin-history model.

module tb_gpio_irq_status;
  localparam int SYNC = 2;
  localparam bit RC   = 1'b1;

  logic        clk = 1'b0;
  logic        rst, ren_i, wen_i, clr_i;
  logic [7:0]  di_i, pin_i, mask_i;
  logic [23:0] trig_i;
  logic [7:0]  reg_o, ovf_o, pend_o;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_reg, m_ovf;
  logic       m_irq;
  logic [7:0] hist[$];

  gpio_irq_status #(.DW(8), .SYNC_STAGES(SYNC), .RC_MODE(RC), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .ren_i(ren_i), .wen_i(wen_i), .di_i(di_i),
    .pin_i(pin_i), .trig_i(trig_i), .mask_i(mask_i), .clr_i(clr_i),
    .reg_o(reg_o), .ovf_o(ovf_o), .pend_o(pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Events for the coming edge, from the pin samples seen since reset release.
  function automatic logic [7:0] events();
    int e = hist.size() + 1;
    logic [7:0] s, p, ev;
    s  = (e - SYNC >= 1)     ? hist[e-SYNC-1] : 8'h00;
    p  = (e - SYNC - 1 >= 1) ? hist[e-SYNC-2] : 8'h00;
    ev = 8'h00;
    if (e < SYNC + 2) return 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (trig_i[3*i +: 3])
        3'd1:    ev[i] = s[i];
        3'd2:    ev[i] = ~s[i];
        3'd3:    ev[i] = s[i] & ~p[i];
        3'd4:    ev[i] = ~s[i] & p[i];
        3'd5:    ev[i] = s[i] ^ p[i];
        default: ev[i] = 1'b0;
      endcase
    end
    return ev;
  endfunction

  task automatic check_all();
    chk("reg", reg_o, m_reg);
    chk("ovf", ovf_o, m_ovf);
    chk("pend", pend_o, m_reg & mask_i);
    chk("irq", {7'b0, irq_o}, {7'b0, m_irq});
  endtask

  task automatic model_reset();
    m_reg = 8'h00;
    m_ovf = 8'h00;
    m_irq = 1'b0;
    hist.delete();
  endtask

  task automatic tick();
    logic [7:0] ev, wclr, rclr, nreg, novf;
    nreg = 8'h00;
    novf = 8'h00;
    if (rst) begin
      ev   = events();
      wclr = wen_i ? di_i : 8'h00;
      rclr = (RC && ren_i) ? m_reg : 8'h00;
      if (!clr_i) begin
        nreg = ev | (m_reg & ~wclr & ~rclr);
        novf = (ev & m_reg) | (m_ovf & ~wclr);
      end
      hist.push_back(pin_i);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_reg = nreg;
      m_ovf = novf;
      m_irq = |(nreg & mask_i);
    end else model_reset();
    check_all();
  endtask

  initial begin
    rst = 1'b0; ren_i = 0; wen_i = 0; clr_i = 0; di_i = 0;
    pin_i = 8'h01; trig_i = 24'h000003; mask_i = 8'h01;
    model_reset();
    #3;
    chk("rst_reg", reg_o, 8'h00);
    chk("rst_ovf", ovf_o, 8'h00);
    chk("rst_irq", {7'b0, irq_o}, 8'h00);
    tick(); tick();
    rst = 1'b1;

    // pin already high at release: no false rising edge
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("warm_reg", reg_o, 8'h00);
      chk("warm_irq", {7'b0, irq_o}, 8'h00);
    end

    // rising latency and W1C
    pin_i = 8'h00;
    repeat (4) tick();
    pin_i = 8'h01;
    tick(); tick();
    chk("lat_early", reg_o, 8'h00);
    tick();
    chk("lat_reg", reg_o, 8'h01);
    tick();
    chk("lat_irq", {7'b0, irq_o}, 8'h01);
    wen_i = 1; di_i = 8'h01;
    tick();
    wen_i = 0; di_i = 8'h00;
    chk("w1c_reg", reg_o, 8'h00);
    tick();
    chk("w1c_irq", {7'b0, irq_o}, 8'h00);

    // both edges on bit 3 -> overflow
    trig_i = 24'h000000; trig_i[11:9] = 3'd5; mask_i = 8'h00;
    pin_i[3] = 1'b1;
    repeat (5) tick();
    pin_i[3] = 1'b0;
    repeat (4) tick();
    chk("both_reg", {7'b0, reg_o[3]}, 8'h01);
    chk("both_ovf", {7'b0, ovf_o[3]}, 8'h01);
    wen_i = 1; di_i = 8'h08;
    tick();
    wen_i = 0; di_i = 8'h00;
    chk("both_w1c_reg", {7'b0, reg_o[3]}, 8'h00);
    chk("both_w1c_ovf", {7'b0, ovf_o[3]}, 8'h00);

    // event vs W1C collision, then vs clr
    trig_i[8:6] = 3'd3;
    pin_i[2] = 1'b1;
    tick(); tick();
    wen_i = 1; di_i = 8'h04;
    tick();
    wen_i = 0; di_i = 8'h00;
    chk("coll_w1c", {7'b0, reg_o[2]}, 8'h01);
    pin_i[2] = 1'b0;
    repeat (3) tick();
    pin_i[2] = 1'b1;
    tick(); tick();
    clr_i = 1;
    tick();
    clr_i = 0;
    chk("coll_clr_reg", reg_o, 8'h00);
    chk("coll_clr_ovf", ovf_o, 8'h00);

    // level-low with read-clear
    trig_i = 24'h000000; trig_i[5:3] = 3'd2;
    pin_i[1] = 1'b0;
    repeat (3) tick();
    ren_i = 1;
    tick();
    ren_i = 0;
    chk("lvl_hold", {7'b0, reg_o[1]}, 8'h01);
    pin_i[1] = 1'b1;
    repeat (3) tick();
    ren_i = 1;
    tick();
    ren_i = 0;
    chk("lvl_rclr", {7'b0, reg_o[1]}, 8'h00);

    // mask gating
    trig_i = {8{3'd3}};
    pin_i = 8'h00;
    repeat (4) tick();
    clr_i = 1; tick(); clr_i = 0;
    mask_i = 8'h00;
    pin_i = 8'hFF;
    repeat (3) tick();
    chk("mask_reg", reg_o, 8'hFF);
    chk("mask_pend", pend_o, 8'h00);
    chk("mask_irq", {7'b0, irq_o}, 8'h00);
    mask_i = 8'h80;
    #1;
    chk("mask_pend80", pend_o, 8'h80);
    tick();
    chk("mask_irq80", {7'b0, irq_o}, 8'h01);

    // randomized traffic with one mid-run reset
    for (int n = 0; n < 400; n++) begin
      pin_i = pin_i ^ (8'($urandom) & 8'($urandom));
      if (n % 16 == 0) trig_i = 24'($urandom);
      if (n % 8 == 0)  mask_i = 8'($urandom);
      wen_i = ($urandom_range(3) == 0);
      di_i  = 8'($urandom);
      ren_i = ($urandom_range(5) == 0);
      clr_i = ($urandom_range(30) == 0);
      tick();
      if (n == 200) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick(); tick();
        rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
